// File: rtl/spi_frame_tx.sv
// -----------------------------------------------------------------------------
// spi_frame_tx
//
// SPI-slave trace frame transmitter. Trace words from the packetiser are
// buffered in a FIFO. They are returned to the SPI host in fixed frames. Each
// frame is one header byte followed by FRAME_WORDS words. The host can send
// command bytes on MOSI: a resync byte, and a frame START that also carries
// the trace port width. SCLK, CS_N and MOSI are oversampled in the clk domain,
// so the whole block runs on a single clock.
//
// Parameters
//   WORD_W       trace word width in bits (multiple of 8, 8..32)
//   FRAME_WORDS  data words per frame (1..15)
//   FIFO_DEPTH   input FIFO depth in words (power of 2, >= FRAME_WORDS)
//   SYNC_BYTE    host resync byte
//   LED_W        activity LED stretch counter width
//
// Ports
//   clk          system clock, at least 4x the SCLK frequency
//   rst          synchronous reset, active high
//   spi_sclk     SPI clock from the host (asynchronous)
//   spi_cs_n     SPI chip select, active low (asynchronous)
//   spi_mosi     host -> block serial data
//   spi_miso     block -> host serial data
//   in_data      trace word to buffer
//   in_valid     in_data is valid
//   in_ready     FIFO can accept a word; a transfer happens on in_valid & in_ready
//   sync_in      trace sync status, reported in the frame header
//   width        trace port width set by the host (0,1: 1 pin; 2: 2 pins; 3: 4 pins)
//   frame_reset  one-cycle pulse when the resync byte is received
//   active_led   high while real data was sent in the last 2^LED_W-1 cycles
//   fifo_level   current FIFO occupancy
// -----------------------------------------------------------------------------
module spi_frame_tx #(
    parameter int         WORD_W      = 16,
    parameter int         FRAME_WORDS = 8,
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         LED_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_sclk,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          sync_in,
    output logic [1:0]                    width,
    output logic                          frame_reset,
    output logic                          active_led,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam int WC_W = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HDR,
        TX_DATA
    } tx_state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers and SCLK edge detection
    // -------------------------------------------------------------------------
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;

    // NOTE: sequential state is always assigned with <= so that every flop
    // samples the pre-edge value of its neighbours; a blocking = here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sclk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_sync[1];
        end
    end

    logic cs_active;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;

    // All three inputs pass the same synchroniser depth, so they stay aligned.
    // Edges only count while the host has the block selected.
    assign cs_active = ~cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = cs_active &  sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = cs_active & ~sclk_sync[1] &  sclk_prev;

    // -------------------------------------------------------------------------
    // Input FIFO
    // -------------------------------------------------------------------------
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              push;
    logic              pop;

    assign in_ready   = (count != LW'(FIFO_DEPTH));
    assign push       = in_valid & in_ready;
    assign fifo_level = count;

    // NOTE: the storage array has no reset. Only pointers and count are
    // cleared, which is enough to make the contents unreachable, and the array
    // can then map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // RX: command byte decode (MOSI sampled on SCLK falling edge)
    // -------------------------------------------------------------------------
    logic [7:0] rx_sr;
    logic [2:0] rx_cnt;
    logic [7:0] rx_next;
    logic       rx_sync_hit;
    logic       start_det;

    assign rx_next     = {rx_sr[6:0], mosi_s};
    assign rx_sync_hit = (rx_next == SYNC_BYTE);

    // A START is 1010_xxx0 and only counts on a byte boundary. The resync byte
    // takes priority because it realigns the byte boundary.
    assign start_det = sclk_fall & ~rx_sync_hit & (rx_cnt == 3'd7) &
                       (rx_next != 8'h00) &
                       ({rx_next[7:4], rx_next[0]} == 5'b1010_0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr       <= 8'h00;
            rx_cnt      <= 3'd0;
            width       <= 2'd3;
            frame_reset <= 1'b0;
        end else begin
            frame_reset <= 1'b0;
            if (!cs_active) begin
                rx_sr  <= 8'h00;
                rx_cnt <= 3'd0;
            end else if (sclk_fall) begin
                rx_sr <= rx_next;
                if (rx_sync_hit) begin
                    rx_cnt      <= 3'd0;
                    frame_reset <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + 3'd1;
                end
                if (start_det) begin
                    width <= rx_next[3:2];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // TX: frame sequencer (MISO updated on SCLK rising edge)
    // -------------------------------------------------------------------------
    tx_state_t         state;
    logic [WORD_W-1:0] tx_sr;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic              real_q;
    logic              start_pend;
    logic [LED_W-1:0]  led_cnt;

    // Bytes go out least-significant byte first, each byte MSB first. The
    // word is byte-reversed once so the shifter only ever sends MSB first.
    function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_W / 8; i++) begin
            r[WORD_W-1-8*i -: 8] = w[8*i +: 8];
        end
        return r;
    endfunction

    logic              hdr_real;
    logic [7:0]        hdr_byte;
    logic [WORD_W-1:0] hdr_word;
    logic [WORD_W-1:0] data_word;
    logic              last_word;
    logic              enter_hdr;
    logic              word_load;

    // NOTE: every signal of an always_comb block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hdr_real  = (count >= LW'(FRAME_WORDS));
        hdr_byte  = {~hdr_real, 4'h0, width, sync_in};
        hdr_word  = '0;
        hdr_word[WORD_W-1 -: 8] = hdr_byte;
        data_word = '0;
        if (real_q && count != '0) begin
            data_word = byte_swap(mem[rd_ptr]);
        end
        last_word = (word_cnt == WC_W'(FRAME_WORDS - 1));
        // A pending START overrides whatever the frame was doing; otherwise a
        // header follows IDLE or the last bit of the last data word.
        enter_hdr = sclk_rise &
                    (start_pend || state == TX_IDLE ||
                     (state == TX_DATA && bit_cnt == BC_W'(WORD_W) && last_word));
        word_load = sclk_rise & ~enter_hdr &
                    ((state == TX_HDR  && bit_cnt == BC_W'(8)) ||
                     (state == TX_DATA && bit_cnt == BC_W'(WORD_W)));
        // A real frame was committed with enough words, so it never underruns;
        // the count check only guards against popping an empty FIFO.
        pop       = word_load & real_q & (count != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            spi_miso   <= 1'b0;
            tx_sr      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            real_q     <= 1'b0;
            start_pend <= 1'b0;
        end else if (!cs_active) begin
            state      <= TX_IDLE;
            spi_miso   <= 1'b0;
            tx_sr      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            real_q     <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            // START arrives on a falling edge; the restart waits for the next
            // rising edge so the header carries the new width.
            if (start_det) begin
                start_pend <= 1'b1;
            end
            if (enter_hdr) begin
                state      <= TX_HDR;
                real_q     <= hdr_real;
                spi_miso   <= hdr_word[WORD_W-1];
                tx_sr      <= hdr_word << 1;
                bit_cnt    <= BC_W'(1);
                word_cnt   <= '0;
                start_pend <= 1'b0;
            end else if (word_load) begin
                state    <= TX_DATA;
                spi_miso <= data_word[WORD_W-1];
                tx_sr    <= data_word << 1;
                bit_cnt  <= BC_W'(1);
                word_cnt <= (state == TX_HDR) ? '0 : word_cnt + WC_W'(1);
            end else if (sclk_rise) begin
                spi_miso <= tx_sr[WORD_W-1];
                tx_sr    <= tx_sr << 1;
                bit_cnt  <= bit_cnt + BC_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Activity LED stretcher
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            led_cnt <= '0;
        end else if (real_q && state != TX_IDLE) begin
            led_cnt <= '1;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - LED_W'(1);
        end
    end

    assign active_led = (led_cnt != '0);

endmodule

// File: tb/tb_spi_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_tx
//
// Directed bench for spi_frame_tx. A behavioural SPI host drives SCLK/MOSI/CS_N
// at 1/16 of clk. MOSI changes mid-low and MISO is sampled just before the
// falling edge. Expected header and data bytes are worked out by hand from the
// frame format.
// -----------------------------------------------------------------------------
module tb_spi_frame_tx;

    localparam int WORD_W      = 16;
    localparam int FRAME_WORDS = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int LED_W       = 8;
    localparam int HALF        = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sync_in = 1'b0;
    logic [1:0]  width;
    logic        frame_reset;
    logic        active_led;
    logic [4:0]  fifo_level;

    int vectors     = 0;
    int miscompares = 0;
    int fr_cnt      = 0;

    spi_frame_tx #(
        .WORD_W      (WORD_W),
        .FRAME_WORDS (FRAME_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_BYTE   (8'hA5),
        .LED_W       (LED_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sync_in     (sync_in),
        .width       (width),
        .frame_reset (frame_reset),
        .active_led  (active_led),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    // Counts clk cycles with frame_reset high, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (frame_reset === 1'b1) fr_cnt++;
    end

    // ---------------------------------------------------------------- host
    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (HALF / 2) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        r = spi_miso;
        spi_sclk = 1'b0;
        repeat (HALF / 2) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_set(input logic v);
        spi_cs_n = v;
        repeat (6) @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] w);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (width !== 2'd3) begin miscompares++; $display("FAIL reset_width got %0d want 3", width); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso got %b want 0", spi_miso); end
        vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        vectors++; if (frame_reset !== 1'b0) begin miscompares++; $display("FAIL reset_frame_reset got %b want 0", frame_reset); end
        vectors++; if (active_led !== 1'b0) begin miscompares++; $display("FAIL reset_led got %b want 0", active_led); end
    endtask

    task automatic test_empty_frame();
        logic [7:0] rx;
        logic [7:0] acc;
        sync_in = 1'b0;
        cs_set(1'b0);
        spi_byte(8'hA8, rx);
        vectors++; if (rx !== 8'h86) begin miscompares++; $display("FAIL empty_first_hdr got %h want 86", rx); end
        vectors++; if (width !== 2'd2) begin miscompares++; $display("FAIL empty_width got %0d want 2", width); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h84) begin miscompares++; $display("FAIL empty_hdr got %h want 84", rx); end
        acc = 8'h00;
        for (int i = 0; i < 2 * FRAME_WORDS; i++) begin
            spi_byte(8'h00, rx);
            acc = acc | rx;
        end
        vectors++; if (acc !== 8'h00) begin miscompares++; $display("FAIL empty_data got or=%h want 00", acc); end
        vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL empty_level got %0d want 0", fifo_level); end
        cs_set(1'b1);
    endtask

    task automatic test_real_frame();
        logic [7:0] rx;
        logic [7:0] exp;
        for (int i = 0; i < FRAME_WORDS; i++) push_word({8'(2 * i + 1), 8'(2 * i + 2)});
        vectors++; if (fifo_level !== 5'd8) begin miscompares++; $display("FAIL real_level_before got %0d want 8", fifo_level); end
        sync_in = 1'b1;
        cs_set(1'b0);
        spi_byte(8'hAC, rx);
        vectors++; if (rx !== 8'h05) begin miscompares++; $display("FAIL real_first_hdr got %h want 05", rx); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h07) begin miscompares++; $display("FAIL real_hdr got %h want 07", rx); end
        vectors++; if (width !== 2'd3) begin miscompares++; $display("FAIL real_width got %0d want 3", width); end
        for (int i = 0; i < 2 * FRAME_WORDS; i++) begin
            spi_byte(8'h00, rx);
            exp = (i % 2 == 0) ? 8'(i + 2) : 8'(i);
            vectors++; if (rx !== exp) begin miscompares++; $display("FAIL real_data[%0d] got %h want %h", i, rx, exp); end
        end
        vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL real_level_after got %0d want 0", fifo_level); end
        vectors++; if (active_led !== 1'b1) begin miscompares++; $display("FAIL real_led_on got %b want 1", active_led); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h87) begin miscompares++; $display("FAIL real_next_hdr got %h want 87", rx); end
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        vectors++; if (active_led !== 1'b0) begin miscompares++; $display("FAIL real_led_off got %b want 0", active_led); end
        cs_set(1'b1);
    endtask

    task automatic test_partial_fill();
        logic [7:0] rx;
        logic [7:0] acc;
        logic [7:0] exp;
        for (int i = 0; i < FRAME_WORDS - 1; i++) push_word({8'hA0 + 8'(i), 8'hB0 + 8'(i)});
        vectors++; if (fifo_level !== 5'd7) begin miscompares++; $display("FAIL part_level7 got %0d want 7", fifo_level); end
        cs_set(1'b0);
        spi_byte(8'hAC, rx);
        vectors++; if (rx !== 8'h87) begin miscompares++; $display("FAIL part_first_hdr got %h want 87", rx); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h87) begin miscompares++; $display("FAIL part_empty_hdr got %h want 87", rx); end
        acc = 8'h00;
        for (int i = 0; i < 2 * FRAME_WORDS; i++) begin
            if (i == FRAME_WORDS) push_word({8'hA7, 8'hB7});
            spi_byte(8'h00, rx);
            acc = acc | rx;
        end
        vectors++; if (acc !== 8'h00) begin miscompares++; $display("FAIL part_empty_data got or=%h want 00", acc); end
        vectors++; if (fifo_level !== 5'd8) begin miscompares++; $display("FAIL part_level8 got %0d want 8", fifo_level); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h07) begin miscompares++; $display("FAIL part_real_hdr got %h want 07", rx); end
        for (int i = 0; i < 2 * FRAME_WORDS; i++) begin
            spi_byte(8'h00, rx);
            exp = (i % 2 == 0) ? 8'hB0 + 8'(i / 2) : 8'hA0 + 8'(i / 2);
            vectors++; if (rx !== exp) begin miscompares++; $display("FAIL part_data[%0d] got %h want %h", i, rx, exp); end
        end
        vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL part_level_after got %0d want 0", fifo_level); end
        cs_set(1'b1);
    endtask

    task automatic test_resync();
        logic [7:0] rx;
        logic       r;
        logic [7:0] sync_b;
        int         base;
        sync_b  = 8'hA5;
        sync_in = 1'b0;
        base    = fr_cnt;
        vectors++; if (base !== 0) begin miscompares++; $display("FAIL resync_no_early_pulse got %0d want 0", base); end
        cs_set(1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
        for (int i = 7; i >= 0; i--) spi_bit(sync_b[i], r);
        vectors++; if (fr_cnt - base !== 1) begin miscompares++; $display("FAIL resync_pulse_cycles got %0d want 1", fr_cnt - base); end
        spi_byte(8'hA4, rx);
        vectors++; if (width !== 2'd1) begin miscompares++; $display("FAIL resync_width got %0d want 1", width); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h82) begin miscompares++; $display("FAIL resync_hdr got %h want 82", rx); end
        cs_set(1'b1);
    endtask

    task automatic test_full_fifo();
        logic [7:0] rx;
        logic       r;
        for (int i = 0; i < FIFO_DEPTH; i++) push_word({8'h30 + 8'(i), 8'h40 + 8'(i)});
        vectors++; if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_level got %0d want 16", fifo_level); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        push_word(16'hDEAD);
        vectors++; if (fifo_level !== 5'd16) begin miscompares++; $display("FAIL full_drop_level got %0d want 16", fifo_level); end
        cs_set(1'b0);
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h02) begin miscompares++; $display("FAIL full_hdr got %h want 02", rx); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h40) begin miscompares++; $display("FAIL full_w0_lo got %h want 40", rx); end
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h30) begin miscompares++; $display("FAIL full_w0_hi got %h want 30", rx); end
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        vectors++; if (fifo_level !== 5'd14) begin miscompares++; $display("FAIL full_level_mid got %0d want 14", fifo_level); end
        cs_set(1'b1);
        repeat (8) @(negedge clk);
        vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL full_cs_miso got %b want 0", spi_miso); end
        vectors++; if (fifo_level !== 5'd14) begin miscompares++; $display("FAIL full_cs_level got %0d want 14", fifo_level); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rx;
        logic       r;
        cs_set(1'b0);
        spi_byte(8'h00, rx);
        vectors++; if (rx !== 8'h02) begin miscompares++; $display("FAIL rstmid_hdr got %h want 02", rx); end
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (fifo_level !== 5'd0) begin miscompares++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
        vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL rstmid_miso got %b want 0", spi_miso); end
        vectors++; if (width !== 2'd3) begin miscompares++; $display("FAIL rstmid_width got %0d want 3", width); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        cs_set(1'b1);
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_real_frame();
        test_partial_fill();
        test_resync();
        test_full_fifo();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
